// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl: fully synchronous Johnson-ring pattern controller.
//
// A programmable prescaler produces a clock enable that advances a WIDTH-bit Johnson ring.
// A small FSM (idle/run/pause) adds run/pause, single-step and direction control.
//
// Ports:
//   io_in[0]    clock, rising edge
//   io_in[1]    reset, synchronous, active-high (not passed through the sample stage)
//   io_in[2]    run   (1 = free-run, 0 = pause)
//   io_in[3]    step  (rising edge advances once while not running)
//   io_in[4]    dir   (0 = forward, 1 = reverse)
//   io_in[7:5]  rate  (step period = 2^(DIV_BASE+rate) clocks)
//   io_out[5:0] ring state, LSB first; bits above WIDTH read 0
//   io_out[6]   tick, one-cycle pulse coincident with each new ring value
//   io_out[7]   phase0, high while ring == 0
//
// Build option: define JSC_SYNC_INPUTS_EN to put io_in[7:2] through two-flop synchronisers
// instead of a single register stage.

module johnson_seq_ctrl #(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned DIV_BASE = 5
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int unsigned CntW = DIV_BASE + 7;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } state_e;

  logic clk;
  logic rst;
  assign clk = io_in[0];
  assign rst = io_in[1];

  // Sample stage for io_in[7:2]
  logic [5:0] s_in;

`ifdef JSC_SYNC_INPUTS_EN
  logic [5:0] sync1_q;
  logic [5:0] sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= io_in[7:2];
      sync2_q <= sync1_q;
    end
  end

  assign s_in = sync2_q;
`else
  logic [5:0] samp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q <= '0;
    end else begin
      samp_q <= io_in[7:2];
    end
  end

  assign s_in = samp_q;
`endif

  logic       s_run;
  logic       s_step;
  logic       s_dir;
  logic [2:0] s_rate;
  assign s_run  = s_in[0];
  assign s_step = s_in[1];
  assign s_dir  = s_in[2];
  assign s_rate = s_in[5:3];

  logic s_step_d_q;
  logic step_pulse;
  assign step_pulse = s_step & ~s_step_d_q;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  ring_q, ring_d;
  logic              tick_q, tick_d;
  logic              advance;

  // Terminal count 2^(DIV_BASE+rate)-1; computed one bit wider so rate=7 yields all ones.
  logic [CntW:0]     term_full;
  logic [CntW-1:0]   term;
  int unsigned       shamt;

  always_comb begin
    shamt     = DIV_BASE + 32'(s_rate);
    term_full = ((CntW + 1)'(1) << shamt) - (CntW + 1)'(1);
    term      = term_full[CntW-1:0];
  end

  logic [WIDTH-1:0] ring_fwd;
  logic [WIDTH-1:0] ring_rev;
  assign ring_fwd = {ring_q[WIDTH-2:0], ~ring_q[WIDTH-1]};
  assign ring_rev = {~ring_q[0], ring_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    advance = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (s_run) begin
          state_d = StRun;
        end else if (step_pulse) begin
          advance = 1'b1;
          state_d = StPause;
        end
      end
      StRun: begin
        // Dropping run freezes cnt and ring on this edge; step is ignored while running.
        if (!s_run) begin
          state_d = StPause;
        end else if (cnt_q >= term) begin
          cnt_d   = '0;
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPause: begin
        // Run has priority over a coincident step; cnt resumes from its held value.
        if (s_run) begin
          state_d = StRun;
        end else if (step_pulse) begin
          advance = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    ring_d = ring_q;
    if (advance) begin
      ring_d = s_dir ? ring_rev : ring_fwd;
    end
    tick_d = advance;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ring_q     <= '0;
      tick_q     <= 1'b0;
      s_step_d_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ring_q     <= ring_d;
      tick_q     <= tick_d;
      s_step_d_q <= s_step;
    end
  end

  always_comb begin
    io_out              = '0;
    io_out[WIDTH-1:0]   = ring_q;
    io_out[6]           = tick_q;
    io_out[7]           = (ring_q == '0);
  end

endmodule
